sram_port_arbiter: RTL and testbench
====================================

Name: sram_port_arbiter

Overview:
- Shares one sram-like memory port between the instruction-fetch requester (read-only) and the data requester (read/write), for a single-port instruction/data memory.
- Arbitrates address phases, latches the winner's request and drives it to memory.
- Tracks the owner of each outstanding transaction in order, and routes each in-order data_ok/rdata back to that owner.

Parameters:
- MAX_OUTSTANDING, 2: max accepted-but-unanswered memory transactions; power of two, >=2.

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
inst_req  in  1  fetch request; held until inst_addr_ok
inst_addr  in  32  fetch address (word read, size 2'b10)
inst_addr_ok  out  1  fetch address phase accepted by memory
inst_data_ok  out  1  fetch read data valid
inst_rdata  out  32  fetch read data
data_req  in  1  data request; held until data_addr_ok
data_wr  in  1  1=write, 0=read
data_size  in  2  0=byte, 1=half, 2=word
data_wstrb  in  4  write byte strobes
data_addr  in  32  data address
data_wdata  in  32  write data
data_addr_ok  out  1  data address phase accepted
data_data_ok  out  1  data response (read data or write ack)
data_rdata  out  32  data read data
mem_req  out  1  memory request
mem_wr  out  1  memory write
mem_size  out  2  memory access size
mem_wstrb  out  4  memory byte strobes
mem_addr  out  32  memory address
mem_wdata  out  32  memory write data
mem_addr_ok  in  1  memory accepted address phase
mem_data_ok  in  1  memory response, in order, >=1 cycle after its addr_ok
mem_rdata  in  32  memory read data

Behaviour:
- Reset (async):
  - State IDLE, outstanding count 0, tag FIFO empty.
  - mem_req=0; all *_addr_ok/*_data_ok=0; latched request fields 0.
- FSM IDLE/GRANT_DATA/GRANT_INST:
  - IDLE, count<MAX_OUTSTANDING: data_req -> GRANT_DATA, else inst_req -> GRANT_INST.
  - The grant latches the winner's wr/size/wstrb/addr/wdata into registers. Inst is latched as wr=0, size=2'b10, wstrb=0, wdata=0.
  - IDLE with FIFO full: no grant; requests wait.
  - GRANT_*: mem_req=1, mem_* driven from latched registers.
  - On mem_addr_ok, the granted requester's *_addr_ok pulses in the same cycle, the owner tag (0=inst, 1=data) is pushed, and the FSM returns to IDLE.
  - Latency: req seen in cycle N gives mem_req in N+1; one idle bubble between consecutive grants.
- Requester withdrawal while granted: ignored; the latched request completes and *_addr_ok still pulses.
- Response routing:
  - inst_data_ok = mem_data_ok & FIFO not empty & head tag==0; data_data_ok likewise for tag==1.
  - On mem_data_ok with FIFO not empty, the tag is popped.
  - inst_rdata = data_rdata = mem_rdata, combinational.
- Count: push and pop in the same cycle leave the count unchanged.
  - Count never exceeds MAX_OUTSTANDING.
  - mem_data_ok with empty FIFO, including a same-cycle first push, is ignored: no *_data_ok pulse and no pop.
- Reset mid-operation drops all outstanding tags. Late mem_data_ok after reset is then ignored per the empty rule.

Optional Feature:
- ARB_RR_EN defined:
  - A last_grant register resets to inst.
  - On contention in IDLE the requester not granted last wins; last_grant updates on every grant.
- Undefined: fixed priority, data always beats inst.

Test Plan:
1. inst_req addr 0x1c000000; mem_addr_ok with mem_req; mem_data_ok 2 cycles later, rdata 0x02800000 -> one inst_addr_ok pulse, one inst_data_ok with inst_rdata 0x02800000; data_addr_ok/data_data_ok stay 0.
2. inst_req and data_req same cycle, data read 0x1c010000 -> first mem_addr=0x1c010000, mem_wr=0; then 0x1c000000. With ARB_RR_EN, a second contention grants inst first.
3. MAX_OUTSTANDING=2, three inst reqs, no mem_data_ok -> two accepted, third mem_req not raised until first mem_data_ok, then accepted.
4. inst accepted, then data accepted, two mem_data_ok pulses -> first asserts inst_data_ok only, second data_data_ok only.
5. Data write addr 0x1c010002, size 1, wstrb 4'b1100, wdata 0xabcd0000 -> mem_wr=1, size 1, wstrb 4'b1100, wdata 0xabcd0000; data_data_ok on ack.
6. reset pulsed with 2 outstanding -> mem_req=0 immediately; later stray mem_data_ok produces no *_data_ok; a new inst_req is then served normally.

Source files
------------

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one sram-like memory port between the instruction
// fetch requester (read-only) and the data requester (read/write).
// Address phases are arbitrated and the winner's request is latched and then
// driven to memory. A small in-order tag FIFO remembers who owns each accepted
// transaction, so every data_ok/rdata goes back to the right requester.
// Optional feature: define ARB_RR_EN for round-robin arbitration on contention.
// When it is undefined, data always beats inst.
module sram_port_arbiter #(
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);

  localparam int PTR_W = $clog2(MAX_OUTSTANDING);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, GRANT_DATA, GRANT_INST} state_t;

  state_t                     state, state_nxt;
  logic [CNT_W-1:0]           count;
  logic [MAX_OUTSTANDING-1:0] tags;
  logic [PTR_W-1:0]           wr_ptr, rd_ptr;
  logic                       fifo_full, fifo_empty, head_tag;
  logic                       grant_data, grant_inst, prefer_data;
  logic                       push, pop;

  logic                       req_wr_p0;
  logic [1:0]                 req_size_p0;
  logic [3:0]                 req_wstrb_p0;
  logic [31:0]                req_addr_p0;
  logic [31:0]                req_wdata_p0;

  assign fifo_full  = (count == CNT_W'(MAX_OUTSTANDING));
  assign fifo_empty = (count == '0);
  assign head_tag   = tags[rd_ptr];

`ifdef ARB_RR_EN
  // Tracks which requester won the most recent grant; the other one wins the next tie.
  logic last_grant_inst;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)           last_grant_inst <= 1'b1;
    else if (grant_data) last_grant_inst <= 1'b0;
    else if (grant_inst) last_grant_inst <= 1'b1;
  end

  assign prefer_data = last_grant_inst;
`else
  assign prefer_data = 1'b1;
`endif

  // Next-state and grant selection; grants only issue from IDLE with FIFO space.
  always_comb begin
    state_nxt  = state;
    grant_data = 1'b0;
    grant_inst = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_full) begin
          if (data_req && (prefer_data || !inst_req)) begin
            grant_data = 1'b1;
            state_nxt  = GRANT_DATA;
          end else if (inst_req) begin
            grant_inst = 1'b1;
            state_nxt  = GRANT_INST;
          end
        end
      end
      GRANT_DATA, GRANT_INST: begin
        if (mem_addr_ok) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Latch the winner's request; an inst fetch is always a full-word read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_wr_p0    <= 1'b0;
      req_size_p0  <= 2'b00;
      req_wstrb_p0 <= 4'b0000;
      req_addr_p0  <= '0;
      req_wdata_p0 <= '0;
    end else if (grant_data) begin
      req_wr_p0    <= data_wr;
      req_size_p0  <= data_size;
      req_wstrb_p0 <= data_wstrb;
      req_addr_p0  <= data_addr;
      req_wdata_p0 <= data_wdata;
    end else if (grant_inst) begin
      req_wr_p0    <= 1'b0;
      req_size_p0  <= 2'b10;
      req_wstrb_p0 <= 4'b0000;
      req_addr_p0  <= inst_addr;
      req_wdata_p0 <= '0;
    end
  end

  // A pop needs an entry already present, so a same-cycle first push is never popped.
  assign push = (state != IDLE) && mem_addr_ok;
  assign pop  = mem_data_ok && !fifo_empty;

  // Owner tag FIFO (0 = inst, 1 = data) and outstanding count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tags   <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        tags[wr_ptr] <= (state == GRANT_DATA);
        wr_ptr       <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign mem_req   = (state != IDLE);
  assign mem_wr    = req_wr_p0;
  assign mem_size  = req_size_p0;
  assign mem_wstrb = req_wstrb_p0;
  assign mem_addr  = req_addr_p0;
  assign mem_wdata = req_wdata_p0;

  assign inst_addr_ok = (state == GRANT_INST) && mem_addr_ok;
  assign data_addr_ok = (state == GRANT_DATA) && mem_addr_ok;
  assign inst_data_ok = pop && !head_tag;
  assign data_data_ok = pop && head_tag;
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Testbench for sram_port_arbiter: directed steps followed by random traffic,
// all checked against a transaction-level model (pending slot + owner queue).
module tb_sram_port_arbiter;

  localparam int MAXO = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req, data_req, data_wr;
  logic [31:0] inst_addr, data_addr, data_wdata, mem_rdata;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic        mem_addr_ok, mem_data_ok;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata;

  sram_port_arbiter #(.MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
    .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int pulses;

  // Reference model: slot = request currently offered to memory (0 none, 1 inst, 2 data).
  int          slot;
  logic        s_wr;
  logic [1:0]  s_size;
  logic [3:0]  s_wstrb;
  logic [31:0] s_addr, s_wdata;
  bit          owners[$];
  bit          last_inst;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    owners.delete();
    slot      = 0;
    last_inst = 1'b1;
  endtask

  task automatic model_check();
    bit has = (owners.size() > 0);
    chk1("mem_req", mem_req, slot != 0);
    chk1("inst_addr_ok", inst_addr_ok, (slot == 1) && mem_addr_ok);
    chk1("data_addr_ok", data_addr_ok, (slot == 2) && mem_addr_ok);
    chk1("inst_data_ok", inst_data_ok, mem_data_ok && has && (owners[0] == 1'b0));
    chk1("data_data_ok", data_data_ok, mem_data_ok && has && (owners[0] == 1'b1));
    chk("inst_rdata", inst_rdata, mem_rdata);
    chk("data_rdata", data_rdata, mem_rdata);
    if (slot != 0) begin
      chk1("mem_wr", mem_wr, s_wr);
      chk("mem_size", 32'(mem_size), 32'(s_size));
      chk("mem_wstrb", 32'(mem_wstrb), 32'(s_wstrb));
      chk("mem_addr", mem_addr, s_addr);
      chk("mem_wdata", mem_wdata, s_wdata);
    end
  endtask

  task automatic model_next();
    int n0 = owners.size();
    bit take_data;
    if (mem_data_ok && n0 > 0) void'(owners.pop_front());
    if (slot != 0) begin
      if (mem_addr_ok) begin
        owners.push_back(slot == 2);
        slot = 0;
      end
    end else if (n0 < MAXO && (inst_req || data_req)) begin
`ifdef ARB_RR_EN
      take_data = data_req && (!inst_req || last_inst);
`else
      take_data = data_req;
`endif
      if (take_data) begin
        slot = 2; s_wr = data_wr; s_size = data_size; s_wstrb = data_wstrb;
        s_addr = data_addr; s_wdata = data_wdata; last_inst = 1'b0;
      end else begin
        slot = 1; s_wr = 1'b0; s_size = 2'b10; s_wstrb = 4'b0000;
        s_addr = inst_addr; s_wdata = '0; last_inst = 1'b1;
      end
    end
  endtask

  // One clock: check against the model with current inputs, advance model, move to next negedge.
  task automatic tick();
    #1;
    if (reset) model_clear();
    model_check();
    if (!reset) model_next();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    inst_req = 0; data_req = 0; data_wr = 0; data_size = 2'b10; data_wstrb = 0;
    inst_addr = 0; data_addr = 0; data_wdata = 0;
    mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    model_clear();
    @(negedge clk);
    // Reset state
    tick();
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk1("rst_mem_wr", mem_wr, 1'b0);
    reset = 1'b0;
    tick();

    // 1: single instruction fetch
    inst_req = 1; inst_addr = 32'h1c00_0000;
    tick();
    mem_addr_ok = 1; #1;
    chk("t1_addr", mem_addr, 32'h1c00_0000);
    chk1("t1_addr_ok", inst_addr_ok, 1'b1);
    tick();
    inst_req = 0; mem_addr_ok = 0;
    tick();
    mem_data_ok = 1; mem_rdata = 32'h0280_0000; #1;
    chk1("t1_data_ok", inst_data_ok, 1'b1);
    chk("t1_rdata", inst_rdata, 32'h0280_0000);
    chk1("t1_no_data", data_data_ok, 1'b0);
    tick();
    mem_data_ok = 0;
    tick();

    // 2: contention, data read wins first (fixed priority / reset last_grant)
    inst_req = 1; inst_addr = 32'h1c00_0000;
    data_req = 1; data_wr = 0; data_addr = 32'h1c01_0000; data_size = 2'b10;
    tick();
    mem_addr_ok = 1; #1;
    chk("t2_first_addr", mem_addr, 32'h1c01_0000);
    chk1("t2_first_wr", mem_wr, 1'b0);
    tick();
    data_req = 0; mem_addr_ok = 0;
    tick();
    mem_addr_ok = 1; #1;
    chk("t2_second_addr", mem_addr, 32'h1c00_0000);
    tick();
    inst_req = 0; mem_addr_ok = 0; mem_data_ok = 1; #1;
    chk1("t2_resp_data", data_data_ok, 1'b1);
    tick();
    chk1("t2_resp_inst", inst_data_ok, 1'b1);
    tick();
    mem_data_ok = 0;

    // 3: FIFO full blocks third request until a response arrives
    inst_req = 1; mem_addr_ok = 1; pulses = 0;
    for (int i = 0; i < 8; i++) begin
      #1; pulses += int'(inst_addr_ok);
      tick();
    end
    chk("t3_accepted", pulses, 2);
    chk1("t3_full_no_req", mem_req, 1'b0);
    mem_data_ok = 1;
    tick();
    mem_data_ok = 0; pulses = 0;
    for (int i = 0; i < 5; i++) begin
      #1; pulses += int'(inst_addr_ok);
      tick();
    end
    chk("t3_third_accepted", pulses, 1);
    inst_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
    for (int i = 0; i < 3; i++) tick();
    mem_data_ok = 0;

    // 4: inst then data accepted; responses routed in order
    inst_req = 1; inst_addr = 32'h1c00_0040;
    tick();
    mem_addr_ok = 1;
    tick();
    inst_req = 0; mem_addr_ok = 0; data_req = 1; data_wr = 0; data_addr = 32'h1c01_0040;
    tick();
    mem_addr_ok = 1;
    tick();
    data_req = 0; mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'h1111_2222; #1;
    chk1("t4_first_inst", inst_data_ok, 1'b1);
    chk1("t4_first_data", data_data_ok, 1'b0);
    tick();
    mem_rdata = 32'h3333_4444; #1;
    chk1("t4_second_inst", inst_data_ok, 1'b0);
    chk1("t4_second_data", data_data_ok, 1'b1);
    tick();
    mem_data_ok = 0;

    // 5: data halfword write
    data_req = 1; data_wr = 1; data_addr = 32'h1c01_0002; data_size = 2'd1;
    data_wstrb = 4'b1100; data_wdata = 32'habcd_0000;
    tick();
    mem_addr_ok = 1; #1;
    chk1("t5_wr", mem_wr, 1'b1);
    chk("t5_size", 32'(mem_size), 32'd1);
    chk("t5_wstrb", 32'(mem_wstrb), 32'hc);
    chk("t5_wdata", mem_wdata, 32'habcd_0000);
    tick();
    data_req = 0; data_wr = 0; mem_addr_ok = 0;
    tick();
    mem_data_ok = 1; #1;
    chk1("t5_ack", data_data_ok, 1'b1);
    tick();
    mem_data_ok = 0;

    // 6: reset with two outstanding, stray response ignored, then normal service
    inst_req = 1; mem_addr_ok = 1;
    for (int i = 0; i < 6; i++) tick();
    inst_req = 0; mem_addr_ok = 0;
    reset = 1; #1;
    chk1("t6_rst_mem_req", mem_req, 1'b0);
    tick();
    reset = 0;
    tick();
    mem_data_ok = 1; #1;
    chk1("t6_stray_inst", inst_data_ok, 1'b0);
    chk1("t6_stray_data", data_data_ok, 1'b0);
    tick();
    mem_data_ok = 0; inst_req = 1; inst_addr = 32'h1c00_0100;
    tick();
    mem_addr_ok = 1; #1;
    chk1("t6_after_rst_ok", inst_addr_ok, 1'b1);
    tick();
    inst_req = 0; mem_addr_ok = 0; mem_data_ok = 1; #1;
    chk1("t6_after_rst_data", inst_data_ok, 1'b1);
    tick();
    mem_data_ok = 0;

    // Random traffic against the model
    for (int i = 0; i < 2000; i++) begin
      inst_req    = ($urandom_range(0, 2) != 0);
      inst_addr   = $urandom;
      data_req    = ($urandom_range(0, 2) != 0);
      data_wr     = 1'($urandom_range(0, 1));
      data_size   = 2'($urandom_range(0, 2));
      data_wstrb  = 4'($urandom);
      data_addr   = $urandom;
      data_wdata  = $urandom;
      mem_addr_ok = 1'($urandom_range(0, 1));
      mem_data_ok = ($urandom_range(0, 2) == 0);
      mem_rdata   = $urandom;
      reset       = ($urandom_range(0, 99) == 0);
      tick();
    end
    reset = 0;
    idle_inputs();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
